aes_iter_core: RTL

//  Iterative AES encryption engine: one round per clock, round keys expanded on the fly.

---
 rtl/aes_pkg.sv | 111 +++++++++++
 rtl/aes_iter_keysched.sv | 68 ++++++
 rtl/aes_iter_core.sv | 130 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_pkg
// Purpose : Shared AES definitions: round count per key length, rcon table,
//           FSM state encoding, GF(2^8) helpers, S-box, MixColumns and the
//           round-key expansion step used by the iterative core.
// Revision: 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_t;

    function automatic int aes_nr(input int key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

    function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = gf_xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box computed as multiplicative inverse (x^254, which maps 0 to 0)
    // followed by the FIPS-197 affine transform; avoids a 256-entry table.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                   ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] aes_sub_word(input logic [31:0] w);
        return {aes_sbox(w[31:24]), aes_sbox(w[23:16]),
                aes_sbox(w[15:8]),  aes_sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] aes_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gf_xtime(a0) ^ gf_xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ gf_xtime(a1) ^ gf_xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ gf_xtime(a2) ^ gf_xtime(a3) ^ a3,
                gf_xtime(a0) ^ a0 ^ a1 ^ a2 ^ gf_xtime(a3)};
    endfunction

    // One 4-word key expansion step. 'last' is the newest schedule word;
    // rot selects RotWord+rcon (all 128-bit steps, even 256-bit steps).
    function automatic logic [127:0] aes_expand(input logic [127:0] prev,
                                                input logic [31:0]  last,
                                                input logic         rot,
                                                input logic [3:0]   rc_idx);
        logic [31:0] t, w0, w1, w2, w3;
        t = aes_sub_word(rot ? {last[23:0], last[31:24]} : last);
        if (rot) t[31:24] = t[31:24] ^ aes_rcon(rc_idx);
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64]  ^ w0;
        w2 = prev[63:32]  ^ w1;
        w3 = prev[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_iter_keysched.sv
`default_nettype none
// ============================================================================
// Module  : aes_iter_keysched
// Purpose : On-the-fly AES round-key generator for the iterative core.
//           rk is the round key for the round currently indexed by rnd.
// Ports   : clk, rst (async, active-high), load (capture key), step (advance
//           after a round), rnd (current round 1..Nr), key, rk (round key).
// Revision: 1.0 - initial release
// ============================================================================
module aes_iter_keysched
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [3:0]          rnd,
    input  logic [KEY_BITS-1:0] key,
    output logic [127:0]        rk
);

    if (KEY_BITS == 256) begin : g_k256
        // 8-word window: r_old holds the older 4 words, r_new the newer 4.
        logic [127:0] r_old;
        logic [127:0] r_new;
        logic [127:0] w_next;
        logic         w_first;

        assign w_first = (rnd == 4'd1);
        // Even rounds use rot+sub+rcon (rcon index rnd/2), odd rounds sub only.
        assign w_next  = aes_expand(r_old, r_new[31:0], ~rnd[0], {1'b0, rnd[3:1]});
        // Round 1 uses the second key half directly.
        assign rk      = w_first ? r_new : w_next;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_old <= '0;
                r_new <= '0;
            end else if (load) begin
                r_old <= key[255:128];
                r_new <= key[127:0];
            end else if (step && !w_first) begin
                r_old <= r_new;
                r_new <= w_next;
            end
        end
    end else begin : g_k128
        logic [127:0] r_key;
        logic [127:0] w_next;

        assign w_next = aes_expand(r_key, r_key[31:0], 1'b1, rnd);
        assign rk     = w_next;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_key <= '0;
            end else if (load) begin
                r_key <= key[127:0];
            end else if (step) begin
                r_key <= w_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_iter_core.sv
`default_nettype none
// ============================================================================
// Module  : aes_iter_core
// Purpose : Iterative AES encryption engine, one round per clock, round keys
//           expanded on the fly, valid/ready on input and output.
// Params  : KEY_BITS = 128 (Nr=10) or 256 (Nr=14).
// Ports   : clk, rst (async, active-high)
//           in_valid/in_ready/pt[127:0]/key[KEY_BITS-1:0]  input block
//           out_valid/out_ready/ct[127:0]                   output block
//           blk_cnt[31:0] completed-block counter (only with AES_PERF_CNT_EN)
// Config  : `define AES_PERF_CNT_EN adds the blk_cnt port and counter.
// Revision: 1.0 - initial release
// ============================================================================
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        pt,
    input  logic [KEY_BITS-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        ct
`ifdef AES_PERF_CNT_EN
    ,
    output logic [31:0]         blk_cnt
`endif
);

    localparam int         NR         = aes_nr(KEY_BITS);
    localparam logic [3:0] C_LAST_RND = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    aes_state_t   r_state;
    aes_state_t   w_state_nxt;
    logic [3:0]   r_rnd;
    logic [127:0] r_blk;
    logic [127:0] w_rk;
    logic [127:0] w_sb;
    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic [127:0] w_round;
    logic         w_accept;
    logic         w_last;

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_rnd == C_LAST_RND);
    // The state register holds the finished block while in DONE and is
    // untouched until the next accept, so it doubles as the ct register.
    assign ct        = r_blk;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = w_accept ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Round datapath; byte i sits at [127-8i -: 8], row i%4, column i/4.
    always_comb begin
        w_sb = '0;
        w_sr = '0;
        w_mc = '0;
        for (int i = 0; i < 16; i++) begin
            w_sb[127-8*i -: 8] = aes_sbox(r_blk[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127-8*(r+4*c) -: 8] = w_sb[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mc[127-32*c -: 32] = aes_mix_col(w_sr[127-32*c -: 32]);
        end
        w_round = (w_last ? w_sr : w_mc) ^ w_rk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_rnd   <= '0;
            r_blk   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_blk <= pt ^ key[KEY_BITS-1 -: 128];
                r_rnd <= 4'd1;
            end else if (r_state == RUN) begin
                r_blk <= w_round;
                r_rnd <= w_last ? 4'd0 : r_rnd + 4'd1;
            end
        end
    end

    aes_iter_keysched #(
        .KEY_BITS (KEY_BITS)
    ) u_keysched (
        .clk  (clk),
        .rst  (rst),
        .load (w_accept),
        .step (r_state == RUN),
        .rnd  (r_rnd),
        .key  (key),
        .rk   (w_rk)
    );

`ifdef AES_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt <= '0;
        end else if (out_valid && out_ready) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
